hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle of pipeline hazard signals between the datapath and
// the hazard controller.
//   master : datapath side, drives the ID/EX observation inputs and consumes
//            the stall/flush controls.
//   slave  : hazard_ctrl side.
// Signals:
//   id_ex_memread, id_ex_register_rd        load in EX and its destination
//   if_id_register_rs1/rs2, if_id_use_rs1/2 sources of the ID instruction
//   ex_branch_taken, ex_mc_start, ex_mc_done EX-stage events
//   pc_write, if_id_write, id_ex_write, control_sel, if_id_flush,
//   id_ex_flush, stall_count                 controller outputs
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_ex_memread;
  logic [REG_AW-1:0] id_ex_register_rd;
  logic [REG_AW-1:0] if_id_register_rs1;
  logic [REG_AW-1:0] if_id_register_rs2;
  logic              if_id_use_rs1;
  logic              if_id_use_rs2;
  logic              ex_branch_taken;
  logic              ex_mc_start;
  logic              ex_mc_done;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_write;
  logic              control_sel;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_ex_memread, id_ex_register_rd, if_id_register_rs1, if_id_register_rs2,
           if_id_use_rs1, if_id_use_rs2, ex_branch_taken, ex_mc_start, ex_mc_done,
    input  pc_write, if_id_write, id_ex_write, control_sel, if_id_flush, id_ex_flush,
           stall_count
  );

  modport slave (
    input  id_ex_memread, id_ex_register_rd, if_id_register_rs1, if_id_register_rs2,
           if_id_use_rs1, if_id_use_rs2, ex_branch_taken, ex_mc_start, ex_mc_done,
    output pc_write, if_id_write, id_ex_write, control_sel, if_id_flush, id_ex_flush,
           stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller. Inserts LOAD_STALL bubbles on a
// load-use hazard, flushes IF/ID and ID/EX on a taken branch, freezes the
// front of the pipe while a multicycle EX op is busy, and keeps a saturating
// count of cycles in which the PC was held.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset; all controls forced low while low
//   hz    : hazard_ctrl_if slave modport (inputs/outputs listed there)
//
// state     | meaning
// IDLE      | no stall in progress; branch, load-use and multicycle start evaluated
// LOAD_WAIT | remaining load-use bubbles, load_cnt_q counts them down
// MC_BUSY   | multicycle EX op in flight, front end frozen until ex_mc_done
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int MC_EN      = 1,
  parameter int CNT_W      = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    MC_BUSY   = 2'd2
  } state_t;

  localparam logic [REG_AW-1:0] RD_ZERO = '0;
  // The IDLE cycle that detects the hazard is the first bubble.
  localparam logic [2:0]        LS_M1   = 3'(LOAD_STALL - 1);

  state_t           state_q, state_d;
  logic [2:0]       load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] stall_q;

  logic hazard;
  logic pc_w, ifid_w, idex_w, ctrl_w, ifid_fl, idex_fl;

  assign hazard = hz.id_ex_memread && (hz.id_ex_register_rd != RD_ZERO) &&
                  ((hz.if_id_use_rs1 && (hz.if_id_register_rs1 == hz.id_ex_register_rd)) ||
                   (hz.if_id_use_rs2 && (hz.if_id_register_rs2 == hz.id_ex_register_rd)));

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    pc_w       = 1'b1;
    ifid_w     = 1'b1;
    idex_w     = 1'b1;
    ctrl_w     = 1'b1;
    ifid_fl    = 1'b0;
    idex_fl    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hz.ex_branch_taken) begin
          ifid_fl = 1'b1;
          idex_fl = 1'b1;
        end else if (hazard) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          ctrl_w = 1'b0;
          if (LOAD_STALL > 1) begin
            state_d    = LOAD_WAIT;
            load_cnt_d = LS_M1;
          end
        end else if ((MC_EN != 0) && hz.ex_mc_start && !hz.ex_mc_done) begin
          // start and done in the same cycle is a single-cycle op: no stall
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_w  = 1'b0;
          state_d = MC_BUSY;
        end
      end
      LOAD_WAIT: begin
        pc_w       = 1'b0;
        ifid_w     = 1'b0;
        ctrl_w     = 1'b0;
        load_cnt_d = load_cnt_q - 3'd1;
        // <= 1 also recovers from an impossible zero count
        if (load_cnt_q <= 3'd1) begin
          state_d    = IDLE;
          load_cnt_d = 3'd0;
        end
      end
      MC_BUSY: begin
        if (hz.ex_mc_done) begin
          state_d = IDLE;
        end else begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_w = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        load_cnt_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_cnt_q <= 3'd0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      if (!pc_w && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
    end
  end

  // In reset every control is held low so the pipe neither advances nor flushes.
  assign hz.pc_write    = rst_n & pc_w;
  assign hz.if_id_write = rst_n & ifid_w;
  assign hz.id_ex_write = rst_n & idex_w;
  assign hz.control_sel = rst_n & ctrl_w;
  assign hz.if_id_flush = rst_n & ifid_fl;
  assign hz.id_ex_flush = rst_n & idex_fl;
  assign hz.stall_count = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl. Three instances share the
// same stimulus:
//   u1 : LOAD_STALL=1, MC_EN=1, CNT_W=16
//   u3 : LOAD_STALL=3, MC_EN=0, CNT_W=16
//   u4 : LOAD_STALL=4, MC_EN=1, CNT_W=3 (small counter for saturation)
// Inputs change 1 time unit after a rising edge; outputs are checked on the
// falling edge.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       memread, use1, use2, br, mcs, mcd;
  logic [4:0] rd, rs1, rs2;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if1 ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if3 ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(3))  if4 ();

  assign if1.id_ex_memread = memread;  assign if1.id_ex_register_rd = rd;
  assign if1.if_id_register_rs1 = rs1; assign if1.if_id_register_rs2 = rs2;
  assign if1.if_id_use_rs1 = use1;     assign if1.if_id_use_rs2 = use2;
  assign if1.ex_branch_taken = br;     assign if1.ex_mc_start = mcs;
  assign if1.ex_mc_done = mcd;

  assign if3.id_ex_memread = memread;  assign if3.id_ex_register_rd = rd;
  assign if3.if_id_register_rs1 = rs1; assign if3.if_id_register_rs2 = rs2;
  assign if3.if_id_use_rs1 = use1;     assign if3.if_id_use_rs2 = use2;
  assign if3.ex_branch_taken = br;     assign if3.ex_mc_start = mcs;
  assign if3.ex_mc_done = mcd;

  assign if4.id_ex_memread = memread;  assign if4.id_ex_register_rd = rd;
  assign if4.if_id_register_rs1 = rs1; assign if4.if_id_register_rs2 = rs2;
  assign if4.if_id_use_rs1 = use1;     assign if4.if_id_use_rs2 = use2;
  assign if4.ex_branch_taken = br;     assign if4.ex_mc_start = mcs;
  assign if4.ex_mc_done = mcd;

  hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .MC_EN(1), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .hz(if1));
  hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .MC_EN(0), .CNT_W(16)) u3 (.clk(clk), .rst_n(rst_n), .hz(if3));
  hazard_ctrl #(.REG_AW(5), .LOAD_STALL(4), .MC_EN(1), .CNT_W(3))  u4 (.clk(clk), .rst_n(rst_n), .hz(if4));

  task automatic clear_in();
    memread = 0; use1 = 0; use2 = 0; br = 0; mcs = 0; mcd = 0;
    rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    next_cyc(); clear_in(); rst_n = 0;
    next_cyc(); next_cyc(); rst_n = 1;
  endtask

  task automatic test_reset();
    next_cyc(); clear_in(); rst_n = 0; br = 1; mcs = 1;
    memread = 1; rd = 5; rs1 = 5; use1 = 1;
    next_cyc();
    @(negedge clk);
    checks++; if (if1.pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc got=%b exp=0", if1.pc_write); end
    checks++; if (if1.id_ex_write !== 1'b0) begin errors++; $display("FAIL rst_idex got=%b exp=0", if1.id_ex_write); end
    checks++; if (if1.control_sel !== 1'b0) begin errors++; $display("FAIL rst_ctrl got=%b exp=0", if1.control_sel); end
    checks++; if (if1.if_id_flush !== 1'b0 || if1.id_ex_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b%b exp=00", if1.if_id_flush, if1.id_ex_flush); end
    checks++; if (if1.stall_count !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", if1.stall_count); end
    next_cyc(); clear_in(); rst_n = 1;
    @(negedge clk);
    checks++; if (if1.pc_write !== 1'b1 || if1.if_id_write !== 1'b1 || if1.id_ex_write !== 1'b1 || if1.control_sel !== 1'b1)
      begin errors++; $display("FAIL rst_release got=%b%b%b%b exp=1111", if1.pc_write, if1.if_id_write, if1.id_ex_write, if1.control_sel); end
  endtask

  task automatic test_load1();
    do_reset();
    next_cyc(); memread = 1; rd = 5; rs1 = 5; use1 = 1;
    @(negedge clk);
    checks++; if (if1.pc_write !== 1'b0 || if1.if_id_write !== 1'b0 || if1.control_sel !== 1'b0 || if1.id_ex_write !== 1'b1)
      begin errors++; $display("FAIL load1_stall got=%b%b%b%b exp=0001", if1.pc_write, if1.if_id_write, if1.control_sel, if1.id_ex_write); end
    next_cyc(); clear_in();
    @(negedge clk);
    checks++; if (if1.pc_write !== 1'b1 || if1.control_sel !== 1'b1) begin errors++; $display("FAIL load1_release got=%b%b exp=11", if1.pc_write, if1.control_sel); end
    checks++; if (if1.stall_count !== 16'd1) begin errors++; $display("FAIL load1_cnt got=%0d exp=1", if1.stall_count); end
  endtask

  task automatic test_load_multi();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      next_cyc(); clear_in();
      if (i == 0) begin memread = 1; rd = 7; rs2 = 7; use2 = 1; rs1 = 3; use1 = 1; end
      @(negedge clk);
      checks++; if (if3.pc_write !== (i >= 3) || if3.control_sel !== (i >= 3))
        begin errors++; $display("FAIL load3_c%0d got=%b%b exp=%b", i, if3.pc_write, if3.control_sel, (i >= 3)); end
      checks++; if (if4.pc_write !== (i >= 4) || if4.if_id_write !== (i >= 4))
        begin errors++; $display("FAIL load4_c%0d got=%b%b exp=%b", i, if4.pc_write, if4.if_id_write, (i >= 4)); end
    end
    checks++; if (if3.stall_count !== 16'd3) begin errors++; $display("FAIL load3_cnt got=%0d exp=3", if3.stall_count); end
    checks++; if (if4.stall_count !== 3'd4) begin errors++; $display("FAIL load4_cnt got=%0d exp=4", if4.stall_count); end
  endtask

  task automatic test_no_stall();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      next_cyc(); clear_in();
      case (i)
        0: begin memread = 1; rd = 0; rs1 = 0; use1 = 1; end
        1: begin memread = 1; rd = 5; rs1 = 5; use1 = 0; rs2 = 3; use2 = 1; end
        2: begin memread = 0; rd = 5; rs1 = 5; use1 = 1; end
        default: begin memread = 1; rd = 6; rs1 = 2; use1 = 1; rs2 = 6; use2 = 0; end
      endcase
      @(negedge clk);
      checks++; if (if1.pc_write !== 1'b1 || if1.control_sel !== 1'b1)
        begin errors++; $display("FAIL nostall_v%0d got=%b%b exp=11", i, if1.pc_write, if1.control_sel); end
    end
    next_cyc(); clear_in();
    @(negedge clk);
    checks++; if (if4.stall_count !== 3'd0) begin errors++; $display("FAIL nostall_cnt got=%0d exp=0", if4.stall_count); end
  endtask

  task automatic test_branch();
    do_reset();
    next_cyc(); memread = 1; rd = 5; rs1 = 5; use1 = 1; br = 1; mcs = 1;
    @(negedge clk);
    checks++; if (if1.if_id_flush !== 1'b1 || if1.id_ex_flush !== 1'b1)
      begin errors++; $display("FAIL br_flush got=%b%b exp=11", if1.if_id_flush, if1.id_ex_flush); end
    checks++; if (if1.pc_write !== 1'b1 || if1.control_sel !== 1'b1)
      begin errors++; $display("FAIL br_nostall got=%b%b exp=11", if1.pc_write, if1.control_sel); end
    next_cyc(); clear_in();
    @(negedge clk);
    checks++; if (if4.pc_write !== 1'b1 || if4.if_id_flush !== 1'b0)
      begin errors++; $display("FAIL br_after got=%b%b exp=10", if4.pc_write, if4.if_id_flush); end
    checks++; if (if4.stall_count !== 3'd0) begin errors++; $display("FAIL br_cnt got=%0d exp=0", if4.stall_count); end
  endtask

  task automatic test_multicycle();
    logic ex;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      next_cyc(); clear_in();
      if (i == 0) mcs = 1;
      if (i == 2) begin br = 1; memread = 1; rd = 4; rs1 = 4; use1 = 1; end
      if (i == 5) mcd = 1;
      ex = (i >= 5);
      @(negedge clk);
      checks++; if (if1.pc_write !== ex || if1.if_id_write !== ex || if1.id_ex_write !== ex)
        begin errors++; $display("FAIL mc_c%0d got=%b%b%b exp=%b", i, if1.pc_write, if1.if_id_write, if1.id_ex_write, ex); end
      if (i == 2) begin
        checks++; if (if1.if_id_flush !== 1'b0 || if1.control_sel !== 1'b1)
          begin errors++; $display("FAIL mc_ignore got=%b%b exp=01", if1.if_id_flush, if1.control_sel); end
      end
      if (i == 0) begin
        checks++; if (if3.pc_write !== 1'b1 || if3.id_ex_write !== 1'b1)
          begin errors++; $display("FAIL mc_disabled got=%b%b exp=11", if3.pc_write, if3.id_ex_write); end
      end
    end
    checks++; if (if1.stall_count !== 16'd5) begin errors++; $display("FAIL mc_cnt got=%0d exp=5", if1.stall_count); end
    next_cyc(); clear_in(); mcs = 1; mcd = 1;
    @(negedge clk);
    checks++; if (if1.pc_write !== 1'b1 || if1.id_ex_write !== 1'b1)
      begin errors++; $display("FAIL mc_same got=%b%b exp=11", if1.pc_write, if1.id_ex_write); end
    next_cyc(); clear_in(); memread = 1; rd = 5; rs1 = 5; use1 = 1; mcs = 1;
    @(negedge clk);
    checks++; if (if1.id_ex_write !== 1'b1 || if1.control_sel !== 1'b0 || if1.pc_write !== 1'b0)
      begin errors++; $display("FAIL h_wins got=%b%b%b exp=100", if1.id_ex_write, if1.control_sel, if1.pc_write); end
    next_cyc(); clear_in();
    @(negedge clk);
    checks++; if (if1.pc_write !== 1'b1 || if1.id_ex_write !== 1'b1)
      begin errors++; $display("FAIL h_wins_after got=%b%b exp=11", if1.pc_write, if1.id_ex_write); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_cyc(); memread = 1; rd = 9; rs1 = 9; use1 = 1;
    next_cyc(); clear_in();
    @(negedge clk);
    checks++; if (if4.pc_write !== 1'b0) begin errors++; $display("FAIL rmid_wait got=%b exp=0", if4.pc_write); end
    next_cyc(); rst_n = 0;
    @(negedge clk);
    checks++; if (if4.pc_write !== 1'b0 || if4.control_sel !== 1'b0 || if4.id_ex_write !== 1'b0 || if4.if_id_flush !== 1'b0)
      begin errors++; $display("FAIL rmid_rst got=%b%b%b%b exp=0000", if4.pc_write, if4.control_sel, if4.id_ex_write, if4.if_id_flush); end
    next_cyc(); rst_n = 1;
    @(negedge clk);
    checks++; if (if4.pc_write !== 1'b1 || if4.control_sel !== 1'b1 || if4.if_id_write !== 1'b1)
      begin errors++; $display("FAIL rmid_idle got=%b%b%b exp=111", if4.pc_write, if4.control_sel, if4.if_id_write); end
    checks++; if (if4.stall_count !== 3'd0) begin errors++; $display("FAIL rmid_cnt got=%0d exp=0", if4.stall_count); end
    next_cyc();
    @(negedge clk);
    checks++; if (if4.pc_write !== 1'b1) begin errors++; $display("FAIL rmid_idle2 got=%b exp=1", if4.pc_write); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      next_cyc(); clear_in();
      if (i == 0 || i == 4) begin memread = 1; rd = 3; rs2 = 3; use2 = 1; end
      @(negedge clk);
      if (i == 4) begin
        checks++; if (if4.stall_count !== 3'd4 || if4.pc_write !== 1'b0)
          begin errors++; $display("FAIL sat_mid got=%0d/%b exp=4/0", if4.stall_count, if4.pc_write); end
      end
    end
    checks++; if (if4.stall_count !== 3'd7 || if4.pc_write !== 1'b1)
      begin errors++; $display("FAIL sat_hold got=%0d/%b exp=7/1", if4.stall_count, if4.pc_write); end
  endtask

  initial begin
    clear_in();
    rst_n = 0;
    test_reset();
    test_load1();
    test_load_multi();
    test_no_stall();
    test_branch();
    test_multicycle();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
